// File: rtl/slink_generic_fc_tx_arb.sv
// Arbitrates the S-Link generic flow-control TX packet port between one control
// channel (strict priority, burst-limited) and NUM_REQ round-robin data requesters.
module slink_generic_fc_tx_arb #(
    parameter int NUM_REQ           = 4,
    parameter int TX_APP_DATA_WIDTH = 64,
    parameter int CTRL_MAX_BURST    = 4
) (
    input  logic                                 link_clk,
    input  logic                                 link_reset,
    input  logic                                 enable,

    input  logic                                 ctrl_valid,
    input  logic [7:0]                           ctrl_data_id,
    input  logic [15:0]                          ctrl_word_count,
    output logic                                 ctrl_ready,

    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ*8-1:0]                 req_data_id,
    input  logic [NUM_REQ*16-1:0]                req_word_count,
    input  logic [NUM_REQ*TX_APP_DATA_WIDTH-1:0] req_app_data,
    output logic [NUM_REQ-1:0]                   req_ready,

    output logic                                 tx_sop,
    output logic [7:0]                           tx_data_id,
    output logic [15:0]                          tx_word_count,
    output logic [TX_APP_DATA_WIDTH-1:0]         tx_app_data,
    output logic [3:0]                           tx_grant_id,
    input  logic                                 tx_advance
);

    localparam int          PW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0]  MAX_BURST = 4'(CTRL_MAX_BURST);
    localparam logic [PW-1:0] LAST_REQ = PW'(NUM_REQ - 1);

    logic                         tx_sop_q, tx_sop_d;
    logic [7:0]                   tx_data_id_q, tx_data_id_d;
    logic [15:0]                  tx_word_count_q, tx_word_count_d;
    logic [TX_APP_DATA_WIDTH-1:0] tx_app_data_q, tx_app_data_d;
    logic [3:0]                   tx_grant_id_q, tx_grant_id_d;
    logic [PW-1:0]                rr_ptr_q, rr_ptr_d;
    logic [3:0]                   streak_q, streak_d;

    logic          capture;
    logic          any_req;
    logic          ctrl_win;
    logic          data_win;
    logic          sel_found;
    logic [PW-1:0] sel_idx;
    logic [PW-1:0] cand;

    assign capture = !tx_sop_q || tx_advance;
    assign any_req = |req_valid;

    // First pending requester after the last one served, wrapping modulo NUM_REQ.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = PW'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!sel_found && req_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Control keeps priority until its streak hits the limit while data waits.
    assign ctrl_win = enable && capture && ctrl_valid &&
                      !((streak_q == MAX_BURST) && any_req);
    assign data_win = enable && capture && !ctrl_win && sel_found;

    always_comb begin
        ctrl_ready = 1'b0;
        req_ready  = '0;
        if (!link_reset) begin
            ctrl_ready = ctrl_win;
            if (data_win) req_ready = NUM_REQ'(1) << sel_idx;
        end
    end

    always_comb begin
        tx_sop_d        = tx_sop_q;
        tx_data_id_d    = tx_data_id_q;
        tx_word_count_d = tx_word_count_q;
        tx_app_data_d   = tx_app_data_q;
        tx_grant_id_d   = tx_grant_id_q;
        rr_ptr_d        = rr_ptr_q;
        streak_d        = streak_q;

        if (ctrl_win) begin
            tx_sop_d        = 1'b1;
            tx_data_id_d    = ctrl_data_id;
            tx_word_count_d = ctrl_word_count;
            tx_app_data_d   = '0;
            tx_grant_id_d   = 4'hF;
        end else if (data_win) begin
            tx_sop_d        = 1'b1;
            tx_data_id_d    = req_data_id[32'(sel_idx)*8 +: 8];
            tx_word_count_d = req_word_count[32'(sel_idx)*16 +: 16];
            tx_app_data_d   = req_app_data[32'(sel_idx)*TX_APP_DATA_WIDTH +: TX_APP_DATA_WIDTH];
            tx_grant_id_d   = 4'(sel_idx);
            rr_ptr_d        = sel_idx;
        end else if (capture) begin
            tx_sop_d = 1'b0;
        end

        if (data_win || (capture && !any_req)) begin
            streak_d = '0;
        end else if (ctrl_win && any_req && (streak_q != MAX_BURST)) begin
            streak_d = streak_q + 4'd1;
        end
    end

    always_ff @(posedge link_clk) begin
        if (link_reset) begin
            tx_sop_q        <= 1'b0;
            tx_data_id_q    <= '0;
            tx_word_count_q <= '0;
            tx_app_data_q   <= '0;
            tx_grant_id_q   <= '0;
            rr_ptr_q        <= LAST_REQ;
            streak_q        <= '0;
        end else begin
            tx_sop_q        <= tx_sop_d;
            tx_data_id_q    <= tx_data_id_d;
            tx_word_count_q <= tx_word_count_d;
            tx_app_data_q   <= tx_app_data_d;
            tx_grant_id_q   <= tx_grant_id_d;
            rr_ptr_q        <= rr_ptr_d;
            streak_q        <= streak_d;
        end
    end

    assign tx_sop        = tx_sop_q;
    assign tx_data_id    = tx_data_id_q;
    assign tx_word_count = tx_word_count_q;
    assign tx_app_data   = tx_app_data_q;
    assign tx_grant_id   = tx_grant_id_q;

endmodule

// File: doc/slink_generic_fc_tx_arb.md
# slink_generic_fc_tx_arb

Link-clock arbiter that shares the S-Link generic flow-control packet transmit interface (`tx_sop` / `tx_data_id` / `tx_word_count` / `tx_app_data`, consumed with `tx_advance`) among one control channel (ACK/NACK/credit packets) and `NUM_REQ` data requesters. It sits between the flow-control state machines or replay buffers and the link layer TX packet port. It provides priority for control traffic, round-robin among data sources, a control-burst starvation limit and back-to-back packet issue without bubbles.

## Interface
Parameters:
- `NUM_REQ`, 4: number of data requesters (2..8).
- `TX_APP_DATA_WIDTH`, 64: payload width.
- `CTRL_MAX_BURST`, 4: maximum consecutive control grants while data is pending (1..15).

Ports:
- `link_clk`  in  1  clock.
- `link_reset`  in  1  reset; synchronous, active-high.
- `enable`  in  1  arbitration enable; low stops new grants.
- `ctrl_valid`  in  1  control packet pending.
- `ctrl_data_id`  in  8  control data ID.
- `ctrl_word_count`  in  16  control word count.
- `ctrl_ready`  out  1  control packet captured this cycle.
- `req_valid`  in  NUM_REQ  per-requester packet pending.
- `req_data_id`  in  NUM_REQ*8  data IDs; requester i occupies [i*8+:8].
- `req_word_count`  in  NUM_REQ*16  word counts.
- `req_app_data`  in  NUM_REQ*TX_APP_DATA_WIDTH  payloads.
- `req_ready`  out  NUM_REQ  one-hot; requester i captured this cycle.
- `tx_sop`  out  1  packet presented to the link layer (registered).
- `tx_data_id`  out  8  registered.
- `tx_word_count`  out  16  registered.
- `tx_app_data`  out  TX_APP_DATA_WIDTH  registered; zero for control packets.
- `tx_grant_id`  out  4  source of the current packet: 0..NUM_REQ-1 for data, 4'hF for control.
- `tx_advance`  in  1  link layer consumed the current packet.

## Operation
- Capture slot: this is any cycle with `tx_sop==0`, or with `tx_sop==1 && tx_advance==1`. Winners are selected and loaded only in a capture slot.
- Winner selection in a capture slot. Nothing is selected when `enable==0`.
  - Control wins if `ctrl_valid` and not (`ctrl_streak==CTRL_MAX_BURST` and any `req_valid`).
  - Otherwise the winner is the first set `req_valid` searching from `rr_ptr+1` upward with wrap modulo `NUM_REQ`.
  - Otherwise there is no winner.
- When there is a winner:
  - The matching `ctrl_ready` or `req_ready[i]` is 1 combinationally in that cycle.
  - The next edge loads the tx_* registers from the winner, sets `tx_sop=1` and sets `tx_grant_id`.
  - On a data grant, `rr_ptr` is set to i.
- No winner in a slot where `tx_advance==1`: the next edge clears `tx_sop` to 0. The ID, count and data fields hold their values.
- `tx_sop==1 && tx_advance==0`: all outputs hold. The ready outputs are 0.
- `ctrl_streak` (4-bit):
  - Increments on a control grant while any `req_valid` is set.
  - Clears on any data grant, or on any capture slot with `req_valid==0`.
  - Saturates at `CTRL_MAX_BURST`.
- Requesters treat a ready pulse as a pop. They present the next packet, or deassert valid, by the following cycle. The arbiter does not latch requests.
- `enable` falling: the in-flight packet completes normally; no new grant follows. `enable` rising: arbitration resumes in the next capture slot.
- Valid dropping before a grant is legal. The request is simply not served.

## Timing
- Reset (synchronous, edge with `link_reset==1`): `tx_sop=0`, `tx_data_id=0`, `tx_word_count=0`, `tx_app_data=0`, `tx_grant_id=0`, `rr_ptr=NUM_REQ-1` (so requester 0 is first), `ctrl_streak=0`. The ready outputs are 0 while reset is asserted. A reset mid-packet drops the packet; the link layer observes `tx_sop=0` after that edge.
- Latency: valid arrives with `tx_sop==0` → ready in the same cycle → `tx_sop=1` at the next edge (1 cycle).
- Back-to-back: `tx_advance` with a pending winner produces a new packet at the next edge with `tx_sop` held at 1 (zero bubbles).
- Simultaneous control and data with `ctrl_streak<CTRL_MAX_BURST`: control wins. Data wins on the next slot only if the streak limit is reached.
- Round-robin wrap: after `rr_ptr=NUM_REQ-1`, the search starts at 0.

## Test plan
- After reset, `req_valid=4'b0001` with `req_data_id[7:0]=8'h20` → `req_ready=4'b0001` in cycle 0; `tx_sop=1`, `tx_data_id=8'h20`, `tx_grant_id=0` at cycle 1; hold until `tx_advance`, then `tx_sop=0`.
- `req_valid=4'b1111` held and `tx_advance` tied to 1 → grants 0,1,2,3,0,1,… on consecutive cycles; `tx_sop` stays at 1.
- `ctrl_valid` (`ctrl_data_id=8'h10`) and `req_valid=4'b0100` held, `CTRL_MAX_BURST=4`, `tx_advance=1` → control is granted 4 times, then requester 2 once, then control 4 more times; `tx_app_data=0` on control packets.
- `tx_advance` held at 0 for 10 cycles while all requests pend → outputs stable and all ready outputs 0; the first `tx_advance` loads the next winner on the following edge.
- `enable` cleared mid-packet → the current packet completes on `tx_advance`; `tx_sop=0` next; no ready pulses until `enable` returns.
- `link_reset` asserted while `tx_sop=1` → `tx_sop=0` and `tx_grant_id=0` after the edge; the first grant after release goes to requester 0.
